// File: rtl/if_id_stage_if.sv
// Fetch/decode handshake and IF/ID register outputs.
// IFID_BUBBLE_CNT_EN adds the bubble_count signal.
interface if_id_stage_if #(
    parameter int unsigned PC_W = 32
);
    logic            if_valid;
    logic [31:0]     if_instr;
    logic [PC_W-1:0] if_pc_plus4;
    logic            stall;
    logic            flush;
    logic            if_ready;
    logic            id_valid;
    logic [31:0]     id_instr;
    logic [PC_W-1:0] id_pc_plus4;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [15:0]     imm16;
    logic            signExtend;
`ifdef IFID_BUBBLE_CNT_EN
    logic [15:0]     bubble_count;

    modport master (
        output if_valid, if_instr, if_pc_plus4, stall, flush,
        input  if_ready, id_valid, id_instr, id_pc_plus4, rs, rt, rd, imm16, signExtend,
        input  bubble_count
    );
    modport slave (
        input  if_valid, if_instr, if_pc_plus4, stall, flush,
        output if_ready, id_valid, id_instr, id_pc_plus4, rs, rt, rd, imm16, signExtend,
        output bubble_count
    );
`else
    modport master (
        output if_valid, if_instr, if_pc_plus4, stall, flush,
        input  if_ready, id_valid, id_instr, id_pc_plus4, rs, rt, rd, imm16, signExtend
    );
    modport slave (
        input  if_valid, if_instr, if_pc_plus4, stall, flush,
        output if_ready, id_valid, id_instr, id_pc_plus4, rs, rt, rd, imm16, signExtend
    );
`endif
endinterface

// File: rtl/if_id_stage.sv
// IF/ID pipeline register with stall (hold), flush (bubble) and registered extend mode.
// Optional IFID_BUBBLE_CNT_EN adds a saturating bubble counter.
module if_id_stage #(
    parameter int unsigned PC_W     = 32,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic           CLK,
    input  logic           Reset_L,
    if_id_stage_if.slave   bus
);

    typedef enum logic [0:0] {StEmpty, StFull} state_e;

    state_e          r_state;
    state_e          w_state_d;
    logic [31:0]     r_instr;
    logic [PC_W-1:0] r_pc_plus4;
    logic            r_sign_ext;
    logic            w_load;
    logic            w_bubble;
    logic            w_ext;

    // Flush beats stall; an idle fetch with no stall also inserts a bubble.
    assign w_load   = ~bus.flush & ~bus.stall & bus.if_valid;
    assign w_bubble = bus.flush | (~bus.stall & ~bus.if_valid);

    // Logical immediates zero-extend; everything else sign-extends.
    always_comb begin
        w_ext = 1'b1;
        case (bus.if_instr[31:26])
            6'h0C, 6'h0D, 6'h0E, 6'h0F: w_ext = 1'b0;
            default:                    w_ext = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StEmpty: if (w_load)   w_state_d = StFull;
            StFull:  if (w_bubble) w_state_d = StEmpty;
            default:               w_state_d = StEmpty;
        endcase
    end

    always_comb begin
        bus.id_valid = (r_state == StFull);
    end

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_instr    <= NOP_WORD;
            r_pc_plus4 <= '0;
            r_sign_ext <= 1'b1;
        end else if (w_bubble) begin
            r_instr    <= NOP_WORD;
            r_pc_plus4 <= '0;
            r_sign_ext <= 1'b1;
        end else if (w_load) begin
            r_instr    <= bus.if_instr;
            r_pc_plus4 <= bus.if_pc_plus4;
            r_sign_ext <= w_ext;
        end
    end

    assign bus.if_ready    = ~bus.stall | bus.flush;
    assign bus.id_instr    = r_instr;
    assign bus.id_pc_plus4 = r_pc_plus4;
    assign bus.signExtend  = r_sign_ext;
    assign bus.rs          = r_instr[25:21];
    assign bus.rt          = r_instr[20:16];
    assign bus.rd          = r_instr[15:11];
    assign bus.imm16       = r_instr[15:0];

`ifdef IFID_BUBBLE_CNT_EN
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            r_bubble_cnt <= '0;
        end else if (w_bubble && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'd1;
        end
    end

    assign bus.bubble_count = r_bubble_cnt;
`endif

endmodule
